// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// fetch_unit (rev 1.0): 6502 fetch stage -- loads PC from the reset vector, then
// fetches opcode plus 0..2 operand bytes and hands whole instructions to the core.
module fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  read_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [15:0] instr_oper,
  output logic [1:0]  instr_len,
  output logic [15:0] instr_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  typedef enum logic [5:0] {
    VEC_LO = 6'b000001,
    VEC_HI = 6'b000010,
    OP     = 6'b000100,
    B1     = 6'b001000,
    B2     = 6'b010000,
    HOLD   = 6'b100000
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] redir_pc, redir_pc_nxt;
  logic        flush, flush_nxt;
  logic        mem_req_nxt, instr_valid_nxt;
  logic [15:0] mem_addr_nxt, instr_oper_nxt, instr_pc_nxt;
  logic [7:0]  instr_opcode_nxt;
  logic [1:0]  instr_len_nxt;
  logic [1:0]  op_len;
  logic        redirecting;

  function automatic logic [1:0] decode_len(input logic [7:0] op);
    if (op == 8'h00 || op == 8'h40 || op == 8'h60 || op[3:0] == 4'h8 || op[3:0] == 4'hA)
      return 2'd1;
    if (op == 8'h20 || op[3:2] == 2'b11 || (op[1:0] == 2'b01 && op[4:2] == 3'b110))
      return 2'd3;
    return 2'd2;
  endfunction

  assign op_len = decode_len(read_data);

  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    redir_pc_nxt     = redir_pc;
    flush_nxt        = flush;
    mem_req_nxt      = mem_req;
    mem_addr_nxt     = mem_addr;
    instr_valid_nxt  = instr_valid;
    instr_opcode_nxt = instr_opcode;
    instr_oper_nxt   = instr_oper;
    instr_len_nxt    = instr_len;
    instr_pc_nxt     = instr_pc;
    redirecting      = (redirect || flush) &&
                       (state == OP || state == B1 || state == B2 || state == HOLD);

    if (redirecting) begin
      // A pending request must still finish on the bus; its data is dropped.
      if (!mem_req || mem_ack) begin
        pc_nxt          = redirect ? redirect_pc : redir_pc;
        state_nxt       = OP;
        mem_req_nxt     = 1'b0;
        flush_nxt       = 1'b0;
        instr_valid_nxt = 1'b0;
        instr_oper_nxt  = 16'h0000;
      end else begin
        flush_nxt = 1'b1;
        if (redirect) redir_pc_nxt = redirect_pc;
      end
    end else begin
      case (state)
        VEC_LO: begin
          if (!mem_req) begin
            mem_req_nxt  = 1'b1;
            mem_addr_nxt = RESET_VECTOR;
          end else if (mem_ack) begin
            pc_nxt[7:0]  = read_data;
            mem_addr_nxt = RESET_VECTOR + 16'd1;
            state_nxt    = VEC_HI;
          end
        end
        VEC_HI: begin
          if (!mem_req) begin
            mem_req_nxt  = 1'b1;
            mem_addr_nxt = RESET_VECTOR + 16'd1;
          end else if (mem_ack) begin
            pc_nxt[15:8] = read_data;
            mem_addr_nxt = {read_data, pc[7:0]};
            state_nxt    = OP;
          end
        end
        OP: begin
          if (!mem_req) begin
            mem_req_nxt  = 1'b1;
            mem_addr_nxt = pc;
          end else if (mem_ack) begin
            instr_opcode_nxt = read_data;
            instr_len_nxt    = op_len;
            instr_pc_nxt     = pc;
            instr_oper_nxt   = 16'h0000;
            if (op_len == 2'd1) begin
              mem_req_nxt     = 1'b0;
              instr_valid_nxt = 1'b1;
              state_nxt       = HOLD;
            end else begin
              mem_addr_nxt = pc + 16'd1;
              state_nxt    = B1;
            end
          end
        end
        B1: begin
          if (!mem_req) begin
            mem_req_nxt  = 1'b1;
            mem_addr_nxt = pc + 16'd1;
          end else if (mem_ack) begin
            instr_oper_nxt[7:0] = read_data;
            if (instr_len == 2'd2) begin
              mem_req_nxt     = 1'b0;
              instr_valid_nxt = 1'b1;
              state_nxt       = HOLD;
            end else begin
              mem_addr_nxt = pc + 16'd2;
              state_nxt    = B2;
            end
          end
        end
        B2: begin
          if (!mem_req) begin
            mem_req_nxt  = 1'b1;
            mem_addr_nxt = pc + 16'd2;
          end else if (mem_ack) begin
            instr_oper_nxt[15:8] = read_data;
            mem_req_nxt          = 1'b0;
            instr_valid_nxt      = 1'b1;
            state_nxt            = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid_nxt = 1'b0;
            pc_nxt          = pc + {14'd0, instr_len};
            state_nxt       = OP;
          end
        end
        default: begin
          state_nxt   = VEC_LO;
          mem_req_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= VEC_LO;
      pc           <= 16'h0000;
      redir_pc     <= 16'h0000;
      flush        <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= 16'h0000;
      instr_valid  <= 1'b0;
      instr_opcode <= 8'h00;
      instr_oper   <= 16'h0000;
      instr_len    <= 2'd0;
      instr_pc     <= 16'h0000;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      redir_pc     <= redir_pc_nxt;
      flush        <= flush_nxt;
      mem_req      <= mem_req_nxt;
      mem_addr     <= mem_addr_nxt;
      instr_valid  <= instr_valid_nxt;
      instr_opcode <= instr_opcode_nxt;
      instr_oper   <= instr_oper_nxt;
      instr_len    <= instr_len_nxt;
      instr_pc     <= instr_pc_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// tb_fetch_unit: memory responder with wait states, bundle monitor and a
// byte-level reference model of the instruction stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [7:0]  read_data = 8'h00;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [7:0]  instr_opcode;
  logic [15:0] instr_oper;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  fetch_unit #(.RESET_VECTOR(16'hFFFC)) dut (
    .clk(clk), .resetn(resetn),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .read_data(read_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_oper(instr_oper), .instr_len(instr_len), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          redir;
    logic [15:0] pc;
    logic [7:0]  op;
    logic [15:0] oper;
    logic [1:0]  len;
    int          cyc;
  } ev_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [7:0]  mem [65536];
  int          wait_cycles = 0;
  bit          rand_wait = 0;
  ev_t         ev_q[$];
  ev_t         bund_q[$];
  logic [15:0] addr_q[$];

  always @(posedge clk) cyc++;

  // Memory: ack after a number of wait cycles; request must stay put meanwhile.
  bit          pend = 0;
  logic [15:0] pend_addr;
  int          wcnt, wcur;
  always @(negedge clk) begin
    if (resetn && pend) begin
      checks++;
      if (!mem_req || mem_addr !== pend_addr) begin
        errors++;
        $display("FAIL mem_hold: req=%b addr=%h required req=1 addr=%h", mem_req, mem_addr, pend_addr);
      end
    end
    if (!resetn || !mem_req) begin
      mem_ack = 1'b0;
      pend    = 0;
    end else begin
      if (!pend) begin
        wcnt = 0;
        wcur = rand_wait ? int'($urandom_range(0, 3)) : wait_cycles;
      end
      if (wcnt >= wcur) begin
        mem_ack   = 1'b1;
        read_data = mem[mem_addr];
        pend      = 0;
      end else begin
        mem_ack   = 1'b0;
        read_data = 8'($urandom);
        wcnt++;
        pend      = 1;
        pend_addr = mem_addr;
      end
    end
  end

  // Monitor samples just before the rising edge what that edge will commit.
  always @(negedge clk) begin
    ev_t e;
    #4;
    if (resetn) begin
      if (mem_req && mem_ack) addr_q.push_back(mem_addr);
      if (redirect) begin
        e = '{1'b1, redirect_pc, 8'h00, 16'h0000, 2'd0, cyc};
        ev_q.push_back(e);
      end else if (instr_valid && instr_ready) begin
        e = '{1'b0, instr_pc, instr_opcode, instr_oper, instr_len, cyc};
        ev_q.push_back(e);
        bund_q.push_back(e);
      end
    end
  end

  function automatic ev_t model(input logic [15:0] pc);
    ev_t r;
    int op, n;
    logic [15:0] a1, a2;
    op = int'(mem[pc]);
    a1 = pc + 16'd1;
    a2 = pc + 16'd2;
    if (op == 0 || op == 'h40 || op == 'h60 || op % 16 == 8 || op % 16 == 10) n = 1;
    else if (op == 'h20 || (op / 4) % 4 == 3 || (op % 4 == 1 && (op / 4) % 8 == 6)) n = 3;
    else n = 2;
    r.redir = 0;
    r.pc    = pc;
    r.op    = mem[pc];
    r.len   = 2'(n);
    r.oper  = 16'h0000;
    if (n >= 2) r.oper[7:0] = mem[a1];
    if (n == 3) r.oper[15:8] = mem[a2];
    r.cyc   = 0;
    return r;
  endfunction

  task automatic do_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    addr_q.delete();
    bund_q.delete();
    ev_q.delete();
    resetn = 1'b1;
  endtask

  task automatic wait_q(input bit addrs, input int n, input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if ((addrs ? addr_q.size() : bund_q.size()) >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_addr, instr_valid, instr_opcode, instr_oper, instr_len, instr_pc} !== 60'd0) begin
      errors++;
      $display("FAIL reset_state: req=%b addr=%h valid=%b op=%h oper=%h len=%0d pc=%h required all 0",
               mem_req, mem_addr, instr_valid, instr_opcode, instr_oper, instr_len, instr_pc);
    end
  endtask

  task automatic test_reset_vector;
    bit ok;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80; mem[16'h8000] = 8'hEA;
    rand_wait = 0; wait_cycles = 0; instr_ready = 1'b1; redirect = 1'b0;
    do_reset;
    wait_q(0, 1, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL vec_timeout: bundles=%0d required 1", bund_q.size()); end
    checks++;
    if ({addr_q[0], addr_q[1], addr_q[2]} !== 48'hFFFC_FFFD_8000) begin
      errors++;
      $display("FAIL vec_addrs: got %h %h %h required fffc fffd 8000", addr_q[0], addr_q[1], addr_q[2]);
    end
    checks++;
    if (bund_q[0].pc !== 16'h8000) begin
      errors++; $display("FAIL vec_pc: got %h required 8000", bund_q[0].pc);
    end
  endtask

  task automatic test_nop_stream;
    bit ok;
    logic [15:0] epc;
    for (int a = 'h8000; a < 'h8004; a++) mem[a] = 8'hEA;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    instr_ready = 1'b1;
    do_reset;
    wait_q(0, 3, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nop_timeout: bundles=%0d required 3", bund_q.size()); end
    for (int i = 0; i < 3; i++) begin
      epc = 16'h8000 + 16'(i);
      checks++;
      if ({bund_q[i].pc, bund_q[i].op, bund_q[i].oper, bund_q[i].len} !== {epc, 8'hEA, 16'h0000, 2'd1}) begin
        errors++;
        $display("FAIL nop_bundle%0d: got pc=%h op=%h oper=%h len=%0d required pc=%h op=ea oper=0000 len=1",
                 i, bund_q[i].pc, bund_q[i].op, bund_q[i].oper, bund_q[i].len, epc);
      end
      if (i > 0) begin
        checks++;
        if (bund_q[i].cyc - bund_q[i-1].cyc != 3) begin
          errors++;
          $display("FAIL nop_gap%0d: got %0d cycles required 3", i, bund_q[i].cyc - bund_q[i-1].cyc);
        end
      end
    end
  endtask

  task automatic test_jmp_wait;
    bit ok;
    mem[16'h8000] = 8'h4C; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
    wait_cycles = 2; instr_ready = 1'b1;
    do_reset;
    wait_q(1, 6, 200, ok);
    checks++;
    if (!ok || bund_q.size() < 1) begin
      errors++; $display("FAIL jmp_timeout: addrs=%0d bundles=%0d required 6/1", addr_q.size(), bund_q.size());
    end
    checks++;
    if ({bund_q[0].pc, bund_q[0].op, bund_q[0].oper, bund_q[0].len} !== {16'h8000, 8'h4C, 16'h1234, 2'd3}) begin
      errors++;
      $display("FAIL jmp_bundle: got pc=%h op=%h oper=%h len=%0d required 8000 4c 1234 3",
               bund_q[0].pc, bund_q[0].op, bund_q[0].oper, bund_q[0].len);
    end
    checks++;
    if (addr_q[5] !== 16'h8003) begin
      errors++; $display("FAIL jmp_next: got %h required 8003", addr_q[5]);
    end
    wait_cycles = 0;
  endtask

  task automatic test_backpressure;
    bit ok;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h55;
    instr_ready = 1'b0;
    do_reset;
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = instr_valid;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: valid=%b required 1", instr_valid); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({instr_valid, mem_req, instr_opcode, instr_oper, instr_len, instr_pc} !==
          {1'b1, 1'b0, 8'hA9, 16'h0055, 2'd2, 16'h8000}) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b req=%b op=%h oper=%h len=%0d pc=%h required 1 0 a9 0055 2 8000",
                 c, instr_valid, mem_req, instr_opcode, instr_oper, instr_len, instr_pc);
      end
    end
    checks++;
    if (addr_q.size() != 4) begin errors++; $display("FAIL bp_nofetch: got %0d acks required 4", addr_q.size()); end
    @(negedge clk);
    instr_ready = 1'b1;
    wait_q(1, 5, 50, ok);
    checks++;
    if (!ok || addr_q[4] !== 16'h8002 || bund_q.size() != 1) begin
      errors++;
      $display("FAIL bp_next: got addr %h bundles %0d required 8002 1", addr_q[4], bund_q.size());
    end
  endtask

  task automatic test_redirect_pending;
    bit ok;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h33; mem[16'h9000] = 8'hEA;
    wait_cycles = 3; instr_ready = 1'b1;
    do_reset;
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = mem_req && mem_addr == 16'h8001;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL redir_b1_timeout: addr=%h required 8001", mem_addr); end
    redirect = 1'b1; redirect_pc = 16'h7000;
    @(negedge clk);
    redirect_pc = 16'h9000;
    @(negedge clk);
    redirect = 1'b0;
    wait_q(0, 1, 100, ok);
    checks++;
    if (!ok || {bund_q[0].pc, bund_q[0].op, bund_q[0].oper, bund_q[0].len} !== {16'h9000, 8'hEA, 16'h0000, 2'd1}) begin
      errors++;
      $display("FAIL redir_bundle: got pc=%h op=%h oper=%h len=%0d required 9000 ea 0000 1",
               bund_q[0].pc, bund_q[0].op, bund_q[0].oper, bund_q[0].len);
    end
    checks++;
    if (addr_q[3] !== 16'h8001 || addr_q[4] !== 16'h9000) begin
      errors++; $display("FAIL redir_addrs: got %h %h required 8001 9000", addr_q[3], addr_q[4]);
    end
    wait_cycles = 0;
  endtask

  task automatic test_wrap;
    bit ok;
    mem[16'hFFFC] = 8'hFF; mem[16'hFFFD] = 8'hFF; mem[16'hFFFF] = 8'hEA; mem[16'h0000] = 8'hEA;
    instr_ready = 1'b1;
    do_reset;
    wait_q(0, 2, 100, ok);
    checks++;
    if (!ok || bund_q[0].pc !== 16'hFFFF || bund_q[1].pc !== 16'h0000) begin
      errors++; $display("FAIL wrap_pc: got %h %h required ffff 0000", bund_q[0].pc, bund_q[1].pc);
    end
    checks++;
    if (addr_q[3] !== 16'h0000) begin errors++; $display("FAIL wrap_addr: got %h required 0000", addr_q[3]); end
  endtask

  task automatic test_reset_b2;
    bit ok;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'h4C; mem[16'h8001] = 8'h00; mem[16'h8002] = 8'h90;
    wait_cycles = 3; instr_ready = 1'b1;
    do_reset;
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = mem_req && mem_addr == 16'h8002;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_b2_timeout: addr=%h required 8002", mem_addr); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_addr, instr_valid, instr_opcode, instr_oper, instr_len, instr_pc} !== 60'd0) begin
      errors++;
      $display("FAIL rst_async: req=%b addr=%h valid=%b op=%h oper=%h len=%0d pc=%h required all 0",
               mem_req, mem_addr, instr_valid, instr_opcode, instr_oper, instr_len, instr_pc);
    end
    @(negedge clk);
    addr_q.delete(); bund_q.delete(); ev_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    wait_q(1, 1, 50, ok);
    checks++;
    if (!ok || addr_q[0] !== 16'hFFFC) begin
      errors++; $display("FAIL rst_restart: got %h required fffc", addr_q[0]);
    end
    wait_cycles = 0;
  endtask

  task automatic test_random;
    logic [15:0] exp_pc;
    int nb;
    bit seen;
    ev_t e, x;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    rand_wait = 1; instr_ready = 1'b0; redirect = 1'b0;
    do_reset;
    exp_pc = {mem[16'hFFFD], mem[16'hFFFC]};
    seen = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = seen && ($urandom_range(0, 24) == 0);
      redirect_pc = 16'($urandom);
      if (bund_q.size() > 0) seen = 1;
    end
    redirect = 1'b0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    nb = 0;
    foreach (ev_q[i]) begin
      e = ev_q[i];
      if (e.redir) exp_pc = e.pc;
      else begin
        x = model(exp_pc);
        checks++;
        if ({e.pc, e.op, e.oper, e.len} !== {x.pc, x.op, x.oper, x.len}) begin
          errors++;
          $display("FAIL rand_bundle%0d: got pc=%h op=%h oper=%h len=%0d required pc=%h op=%h oper=%h len=%0d",
                   nb, e.pc, e.op, e.oper, e.len, x.pc, x.op, x.oper, x.len);
        end
        exp_pc = exp_pc + 16'(x.len);
        nb++;
      end
    end
    checks++;
    if (nb < 50) begin errors++; $display("FAIL rand_count: got %0d bundles required >= 50", nb); end
    rand_wait = 0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    test_reset;
    test_reset_vector;
    test_nop_stream;
    test_jmp_wait;
    test_backpressure;
    test_redirect_pending;
    test_wrap;
    test_reset_b2;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the 6502 processor core.
- After reset it reads the reset vector and loads the PC.
- It then reads each instruction's opcode and 0–2 operand bytes from memory, and presents the whole instruction to the core through a valid/ready handshake.
- The core can redirect fetch to a new PC (JMP, branches); in-flight bytes are discarded.

Parameters:
- RESET_VECTOR, 16'hFFFC, address of the reset vector low byte; the high byte is at RESET_VECTOR+1.

Ports:
- clk  input  1  system clock, all state on rising edge
- resetn  input  1  asynchronous, active-low reset
- mem_addr  output  16  byte address of the current read request
- mem_req  output  1  read request; held with mem_addr stable until mem_ack
- mem_ack  input  1  read complete; read_data valid in the same cycle
- read_data  input  8  memory read data
- instr_valid  output  1  instruction bundle valid
- instr_ready  input  1  core accepts the bundle
- instr_opcode  output  8  opcode byte
- instr_oper  output  16  {oper_2, oper_1}; unused bytes are 0
- instr_len  output  2  instruction length in bytes (1..3)
- instr_pc  output  16  address of the opcode byte
- redirect  input  1  core requests a fetch restart
- redirect_pc  input  16  new fetch PC, sampled when redirect=1

Behaviour:
- Reset (resetn=0, async):
  - mem_req=0, mem_addr=0, instr_valid=0, instr_opcode=0, instr_oper=0, instr_len=0, instr_pc=0, PC=0, flush=0.
  - State goes to VEC_LO.
- All outputs are registered.
- Memory handshake:
  - A transfer completes on a clock edge where mem_req=1 and mem_ack=1.
  - mem_addr must not change while mem_req=1 and no ack has arrived.
  - Back-to-back requests are allowed: mem_req stays 1 and mem_addr updates on the ack edge.
  - Zero wait states give one byte per cycle.
- State machine, one-hot:
  - VEC_LO: req at RESET_VECTOR; on ack PC[7:0]<=read_data -> VEC_HI.
  - VEC_HI: req at RESET_VECTOR+1; on ack PC[15:8]<=read_data -> OP.
  - OP: req at PC; on ack capture opcode, compute len, instr_pc<=PC.
    - len=1 -> HOLD.
    - otherwise -> B1.
  - B1: req at PC+1; on ack oper_1<=read_data.
    - len=2 -> HOLD.
    - len=3 -> B2.
  - B2: req at PC+2; on ack oper_2<=read_data -> HOLD.
  - HOLD: mem_req=0, instr_valid=1, all bundle fields stable.
    - On instr_ready: valid<=0, PC<=PC+len -> OP.
    - The next mem_req is asserted the cycle after acceptance.
- Length rule, evaluated in this order:
  - 1 if opcode is 00, 40 or 60, or opcode[3:0] is 8 or A.
  - 3 if opcode is 20, or opcode[3:2]=11, or (opcode[1:0]=01 and opcode[4:2]=110).
  - 2 otherwise.
  - Examples: EA->1, 4C->3, A9->2, 19->3, 10->2.
- PC arithmetic is 16-bit modulo: FFFF+1=0000. Operand addresses wrap the same way.
- Redirect, in OP/B1/B2/HOLD:
  - No outstanding un-acked request: PC<=redirect_pc, instr_valid<=0, oper bytes cleared -> OP next cycle.
  - An un-acked request is pending: keep mem_req/mem_addr until ack, discard its data (flush=1), then go to OP at redirect_pc.
  - redirect in the same cycle as instr_ready in HOLD: redirect wins; PC becomes redirect_pc, not PC+len.
  - redirect asserted again during a flush: the latest redirect_pc wins.
- Redirect is ignored in VEC_LO/VEC_HI.
- Reset asserted mid-operation: immediate return to reset values. Any outstanding memory request is abandoned; memory must tolerate mem_req dropping.

Test Plan:
- Reset vector: memory FFFC=00, FFFD=80, zero wait.
  - Required: mem_addr sequence FFFC, FFFD, 8000.
  - Required: first bundle has instr_pc=8000.
- NOP stream: 8000..8002=EA, instr_ready tied 1.
  - Required: bundles EA/len1 at 8000, 8001, 8002.
  - Required: instr_oper=0000.
  - Required: two cycles between valid pulses.
- JMP with 2 wait states per byte: 8000=4C 34 12.
  - Required: bundle opcode 4C, oper 1234, len 3, instr_pc 8000.
  - Required: mem_addr stable through each wait.
  - Required: next fetch at 8003.
- Backpressure: A9 55 at 8000, instr_ready low for 5 cycles.
  - Required: valid held with opcode A9/oper 0055/len 2 unchanged and mem_req=0.
  - Required: after accept, next fetch at 8002.
- Redirect during pending B1 request (ack delayed 3 cycles), redirect_pc=9000.
  - Required: the B1 request completes and its data is dropped.
  - Required: no bundle is emitted for 8000.
  - Required: next mem_addr is 9000.
- Wrap and reset: 1-byte opcode at FFFF.
  - Required: next fetch at 0000.
- Wrap and reset: assert resetn=0 during B2.
  - Required: outputs go to reset values asynchronously.
  - Required: after release, mem_addr restarts at FFFC.
